// File: rtl/raster_pkg.sv
// Shared constants and FSM state encoding for the raster scanner.
package raster_pkg;

   localparam int DEF_DATA_WIDTH = 16;
   localparam int DEF_ADDR_WIDTH = 32;

   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_ISSUE     = 3'd1;
   localparam logic [2:0] ST_WAIT_LOW  = 3'd2;
   localparam logic [2:0] ST_WAIT_HIGH = 3'd3;
   localparam logic [2:0] ST_EMIT      = 3'd4;
   localparam logic [2:0] ST_ADVANCE   = 3'd5;
   localparam logic [2:0] ST_FINISH    = 3'd6;

   typedef enum logic [2:0] {
      IDLE      = ST_IDLE,
      ISSUE     = ST_ISSUE,
      WAIT_LOW  = ST_WAIT_LOW,
      WAIT_HIGH = ST_WAIT_HIGH,
      EMIT      = ST_EMIT,
      ADVANCE   = ST_ADVANCE,
      FINISH    = ST_FINISH
   } state_t;

endpackage

// File: rtl/raster_counter.sv
// Column/row counter pair for the raster walk, with end-of-row/end-of-window flags.
// RASTER_SERPENTINE_EN mirrors the column index on odd rows (boustrophedon order).
module raster_counter
   import raster_pkg::*;
#(
   parameter int DW = DEF_DATA_WIDTH
) (
   input  logic          gclk,
   input  logic          grst_n,
   input  logic          clr,
   input  logic          adv,
   input  logic [DW-1:0] size_w,
   input  logic [DW-1:0] size_h,
   output logic [DW-1:0] cx,
   output logic [DW-1:0] cy,
   output logic [DW-1:0] map_x,
   output logic          last_col,
   output logic          last_pt
);

   localparam logic [DW-1:0] ONE = DW'(1);

   always_ff @(posedge gclk) begin
      if (!grst_n) begin
         cx <= '0;
         cy <= '0;
      end else if (clr) begin
         cx <= '0;
         cy <= '0;
      end else if (adv) begin
         if (last_col) begin
            cx <= '0;
            cy <= cy + ONE;
         end else begin
            cx <= cx + ONE;
         end
      end
   end

   assign last_col = (cx == size_w - ONE);
   assign last_pt  = last_col && (cy == size_h - ONE);

`ifdef RASTER_SERPENTINE_EN
   assign map_x = cy[0] ? (size_w - ONE - cx) : cx;
`else
   assign map_x = cx;
`endif

endmodule

// File: rtl/raster_scanner.sv
// Raster-order window walker feeding the linear-address unit and forwarding its result.
// Optional serpentine order via RASTER_SERPENTINE_EN (see raster_counter).
module raster_scanner
   import raster_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
   input  logic                  Clk,
   input  logic                  ResetN,
   input  logic                  Go,
   input  logic [DATA_WIDTH-1:0] OriginX,
   input  logic [DATA_WIDTH-1:0] OriginY,
   input  logic [DATA_WIDTH-1:0] SizeW,
   input  logic [DATA_WIDTH-1:0] SizeH,
   output logic                  Busy,
   output logic                  Done,
   output logic [DATA_WIDTH-1:0] LuaX,
   output logic [DATA_WIDTH-1:0] LuaY,
   output logic                  LuaStart,
   input  logic                  LuaReady,
   input  logic [ADDR_WIDTH-1:0] LuaAddress,
   output logic [ADDR_WIDTH-1:0] AddrOut,
   output logic                  AddrValid,
   input  logic                  AddrAck
);

   state_t                state, nstate;
   logic [DATA_WIDTH-1:0] org_x, org_y, sz_w, sz_h;
   logic [DATA_WIDTH-1:0] cx, cy, map_x;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic                  clr, adv, last_col, last_pt;

   raster_counter #(.DW(DATA_WIDTH)) u_cnt (
      .gclk     (Clk),
      .grst_n   (ResetN),
      .clr      (clr),
      .adv      (adv),
      .size_w   (sz_w),
      .size_h   (sz_h),
      .cx       (cx),
      .cy       (cy),
      .map_x    (map_x),
      .last_col (last_col),
      .last_pt  (last_pt)
   );

   always_ff @(posedge Clk) begin
      if (!ResetN) begin
         state  <= IDLE;
         org_x  <= '0;
         org_y  <= '0;
         sz_w   <= '0;
         sz_h   <= '0;
         addr_q <= '0;
      end else begin
         state <= nstate;
         if (state == IDLE && Go) begin
            org_x <= OriginX;
            org_y <= OriginY;
            sz_w  <= SizeW;
            sz_h  <= SizeH;
         end
         if (state == WAIT_HIGH && LuaReady)
            addr_q <= LuaAddress;
      end
   end

   // ISSUE waits for Ready so Start can never rise against a busy address unit.
   always_comb begin
      nstate = state;
      clr    = 1'b0;
      adv    = 1'b0;
      case (state)
         IDLE: if (Go) begin
            clr    = 1'b1;
            nstate = (SizeW == '0 || SizeH == '0) ? FINISH : ISSUE;
         end
         ISSUE:     if (LuaReady)  nstate = WAIT_LOW;
         WAIT_LOW:  if (!LuaReady) nstate = WAIT_HIGH;
         WAIT_HIGH: if (LuaReady)  nstate = EMIT;
         EMIT:      if (AddrAck)   nstate = ADVANCE;
         ADVANCE: begin
            if (last_pt) begin
               nstate = FINISH;
            end else begin
               adv    = 1'b1;
               nstate = ISSUE;
            end
         end
         FINISH:  nstate = IDLE;
         default: nstate = IDLE;
      endcase
   end

   assign Busy      = (state != IDLE) && (state != FINISH);
   assign Done      = (state == FINISH);
   assign LuaStart  = (state == ISSUE && LuaReady) || (state == WAIT_LOW);
   assign AddrValid = (state == EMIT);
   assign AddrOut   = addr_q;
   assign LuaX      = org_x + map_x;
   assign LuaY      = org_y + cy;

endmodule

// File: tb/tb_raster_scanner.sv
// Directed bench for raster_scanner with a behavioural address unit (addr = y*10 + x).
module tb_raster_scanner;

   localparam int DW    = 16;
   localparam int AW    = 32;
   localparam int BLOCK = 10;
   localparam int LAT   = 2;

   logic          Clk = 1'b0;
   logic          ResetN, Go;
   logic [DW-1:0] OriginX, OriginY, SizeW, SizeH;
   logic          Busy, Done, LuaStart, LuaReady, AddrValid, AddrAck;
   logic [DW-1:0] LuaX, LuaY;
   logic [AW-1:0] LuaAddress, AddrOut;

   always #5 Clk = ~Clk;

   raster_scanner #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .Clk(Clk), .ResetN(ResetN), .Go(Go),
      .OriginX(OriginX), .OriginY(OriginY), .SizeW(SizeW), .SizeH(SizeH),
      .Busy(Busy), .Done(Done), .LuaX(LuaX), .LuaY(LuaY),
      .LuaStart(LuaStart), .LuaReady(LuaReady), .LuaAddress(LuaAddress),
      .AddrOut(AddrOut), .AddrValid(AddrValid), .AddrAck(AddrAck)
   );

   // address unit model: Ready drops after Start, returns LAT+1 cycles later
   logic [DW-1:0] lx_q, ly_q;
   int            lat_cnt;
   always @(posedge Clk) begin
      if (!ResetN) begin
         LuaReady   <= 1'b1;
         LuaAddress <= '0;
         lat_cnt    <= 0;
      end else if (LuaReady) begin
         if (LuaStart) begin
            LuaReady <= 1'b0;
            lx_q     <= LuaX;
            ly_q     <= LuaY;
            lat_cnt  <= LAT;
         end
      end else if (lat_cnt > 0) begin
         lat_cnt <= lat_cnt - 1;
      end else begin
         LuaReady   <= 1'b1;
         LuaAddress <= AW'(int'(ly_q) * BLOCK + int'(lx_q));
      end
   end

   // downstream: Ack stays low for ack_hold cycles of each valid address
   int ack_hold = 0;
   int vcnt = 0;
   always @(posedge Clk) vcnt <= AddrValid ? vcnt + 1 : 0;
   assign AddrAck = (vcnt >= ack_hold);

   logic [AW-1:0] got_q[$];
   int            done_cnt = 0, start_cnt = 0, start_viol = 0, stable_err = 0;
   logic          start_p = 1'b0, hold_p = 1'b0;
   logic [AW-1:0] hold_v = '0;
   always @(posedge Clk) begin
      if (ResetN) begin
         if (AddrValid && AddrAck) got_q.push_back(AddrOut);
         if (Done) done_cnt <= done_cnt + 1;
         if (LuaStart) start_cnt <= start_cnt + 1;
         if (LuaStart && !start_p && !LuaReady) start_viol <= start_viol + 1;
         if (hold_p && AddrValid && AddrOut !== hold_v) stable_err <= stable_err + 1;
         start_p <= LuaStart;
         hold_p  <= AddrValid && !AddrAck;
         hold_v  <= AddrOut;
      end else begin
         start_p <= 1'b0;
         hold_p  <= 1'b0;
      end
   end

   int checks = 0, errors = 0;

   task automatic chk(input string nm, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0d want %0d", nm, act, exp);
      end
   endtask

   typedef struct packed {
      logic [DW-1:0]      ox, oy, w, h;
      logic [7:0]         ackh, n;
      logic [5:0][AW-1:0] e;
   } vec_t;

   function automatic vec_t mk(input int ox, oy, w, h, ah, n,
                               input int e0, e1, e2, e3, e4, e5);
      vec_t v;
      v.ox = DW'(ox); v.oy = DW'(oy); v.w = DW'(w); v.h = DW'(h);
      v.ackh = 8'(ah); v.n = 8'(n);
      v.e[0] = AW'(e0); v.e[1] = AW'(e1); v.e[2] = AW'(e2);
      v.e[3] = AW'(e3); v.e[4] = AW'(e4); v.e[5] = AW'(e5);
      return v;
   endfunction

   task automatic wait_done(input string nm);
      bit seen = 0;
      for (int i = 0; i < 2000 && !seen; i++) begin
         if (Done) seen = 1;
         else @(negedge Clk);
      end
      chk(nm, seen, 1);
   endtask

   task automatic run_scan(input vec_t v);
      int d0, s0;
      ack_hold = int'(v.ackh);
      got_q.delete();
      d0 = done_cnt;
      s0 = start_cnt;
      OriginX = v.ox; OriginY = v.oy; SizeW = v.w; SizeH = v.h;
      Go = 1'b1;
      @(negedge Clk);
      Go = 1'b0;
      // window inputs change after acceptance and must be ignored
      OriginX = 16'hAAAA; OriginY = 16'h5555; SizeW = 16'd7; SizeH = 16'd7;
      if (v.n == 0) begin
         chk("zero_done_next", Done, 1);
         chk("zero_busy", Busy, 0);
      end else begin
         chk("busy_after_go", Busy, 1);
      end
      wait_done("done_seen");
      @(negedge Clk);
      chk("done_pulse", Done, 0);
      @(negedge Clk);
      chk("busy_after_done", Busy, 0);
      chk("done_count", done_cnt - d0, 1);
      chk("addr_count", got_q.size(), int'(v.n));
      for (int k = 0; k < int'(v.n) && k < got_q.size(); k++)
         chk("addr_value", got_q[k], v.e[k]);
      if (v.n == 0) chk("no_lua_start", start_cnt - s0, 0);
   endtask

   vec_t tbl[6];

   initial begin
      #2000000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      int d0;
      bit ok;
`ifdef RASTER_SERPENTINE_EN
      tbl[0] = mk(4, 5, 2, 2, 0, 4, 54, 55, 65, 64, 0, 0);
      tbl[3] = mk(7, 2, 3, 2, 0, 6, 27, 28, 29, 39, 38, 37);
`else
      tbl[0] = mk(4, 5, 2, 2, 0, 4, 54, 55, 64, 65, 0, 0);
      tbl[3] = mk(7, 2, 3, 2, 0, 6, 27, 28, 29, 37, 38, 39);
`endif
      tbl[1] = mk(0, 0, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0);
      tbl[2] = mk(0, 0, 3, 1, 5, 3, 0, 1, 2, 0, 0, 0);
      tbl[4] = mk(65535, 0, 2, 1, 0, 2, 65535, 0, 0, 0, 0, 0);
      tbl[5] = mk(3, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0);

      ResetN = 1'b0; Go = 1'b0;
      OriginX = '0; OriginY = '0; SizeW = '0; SizeH = '0;
      repeat (3) @(negedge Clk);
      chk("rst_busy", Busy, 0);
      chk("rst_done", Done, 0);
      chk("rst_start", LuaStart, 0);
      chk("rst_valid", AddrValid, 0);
      chk("rst_addr", AddrOut, 0);
      ResetN = 1'b1;
      @(negedge Clk);

      for (int t = 0; t < 6; t++) run_scan(tbl[t]);

      // reset in the middle of a 4x4 scan, after the second address
      ack_hold = 0;
      got_q.delete();
      d0 = done_cnt;
      OriginX = 0; OriginY = 0; SizeW = 4; SizeH = 4;
      Go = 1'b1;
      @(negedge Clk);
      Go = 1'b0;
      ok = 0;
      for (int i = 0; i < 500 && !ok; i++) begin
         if (got_q.size() >= 2) ok = 1;
         else @(negedge Clk);
      end
      chk("mid_two_addrs", ok, 1);
      ResetN = 1'b0;
      @(negedge Clk);
      ResetN = 1'b1;
      chk("mid_rst_busy", Busy, 0);
      chk("mid_rst_valid", AddrValid, 0);
      chk("mid_rst_start", LuaStart, 0);
      chk("mid_rst_luax", LuaX, 0);
      chk("mid_rst_luay", LuaY, 0);
      chk("mid_rst_addr", AddrOut, 0);
      repeat (20) @(negedge Clk);
      chk("mid_no_done", done_cnt - d0, 0);
      chk("mid_no_more", got_q.size(), 2);
      if (got_q.size() >= 2) begin
         chk("mid_addr0", got_q[0], 0);
         chk("mid_addr1", got_q[1], 1);
      end
      run_scan(mk(1, 1, 1, 1, 0, 1, 11, 0, 0, 0, 0, 0));

      // Go held high for a whole 3x1 scan and through FINISH
      got_q.delete();
      d0 = done_cnt;
      OriginX = 0; OriginY = 0; SizeW = 3; SizeH = 1;
      Go = 1'b1;
      @(negedge Clk);
      wait_done("rep_done1");
      @(negedge Clk);
      chk("rep_finish_go_busy", Busy, 0);
      chk("rep_finish_go_done", Done, 0);
      chk("rep_count1", got_q.size(), 3);
      chk("rep_done_cnt1", done_cnt - d0, 1);
      @(negedge Clk);
      Go = 1'b0;
      chk("rep_go_accepted", Busy, 1);
      wait_done("rep_done2");
      repeat (2) @(negedge Clk);
      chk("rep_count2", got_q.size(), 6);
      chk("rep_done_cnt2", done_cnt - d0, 2);
      if (got_q.size() == 6)
         for (int k = 0; k < 6; k++) chk("rep_addr", got_q[k], k % 3);

      chk("start_rise_ready", start_viol, 0);
      chk("addr_stable", stable_err, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
